// File: rtl/data_mem_store_buf.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_store_buf
// Brief    : Store formatter and FIFO buffer feeding the data memory write port,
//            with misaligned-store flagging and load-after-store hazard detect.
// Revision : 1.0
// ============================================================================
module data_mem_store_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  input  logic [ADDR_WIDTH-1:0]      write_data_i,
  input  logic [1:0]                 mem_type_i,
  output logic                       misalign_o,
  input  logic                       ld_valid_i,
  input  logic [ADDR_WIDTH-1:0]      ld_addr_i,
  output logic                       hazard_o,
  output logic                       mem_we_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [ADDR_WIDTH-1:0]      mem_wdata_o,
  output logic [3:0]                 mem_be_o,
  input  logic                       mem_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [ADDR_WIDTH-3:0] r_addr [DEPTH];
  logic [ADDR_WIDTH-1:0] r_data [DEPTH];
  logic [3:0]            r_be   [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_misalign;

  logic [1:0]            w_lane;
  logic                  w_is_byte;
  logic                  w_is_half;
  logic                  w_misalign;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic [ADDR_WIDTH-1:0] w_wdata;
  logic [3:0]            w_be;
  logic                  w_hazard;
  logic                  w_unused_ld_lsb;

  assign w_lane     = addr_i[1:0];
  assign w_is_byte  = (mem_type_i == 2'b01);
  assign w_is_half  = (mem_type_i == 2'b10);
  assign w_misalign = w_is_half ? w_lane[0] : (!w_is_byte && (w_lane != 2'b00));

  assign w_empty    = (r_count == '0);
  assign st_ready_o = (r_count < c_depth);
  assign w_accept   = st_valid_i && st_ready_o;
  assign w_push     = w_accept && !w_misalign;
  assign w_pop      = !w_empty && mem_ready_i;

  // Lane replication lets the memory use the byte enables directly.
  always_comb begin
    w_wdata = write_data_i;
    w_be    = 4'b1111;
    if (w_is_byte) begin
      w_wdata = {4{write_data_i[7:0]}};
      w_be    = 4'b0001 << w_lane;
    end else if (w_is_half) begin
      w_wdata = {2{write_data_i[15:0]}};
      w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= addr_i[ADDR_WIDTH-1:2];
      r_data[r_wptr] <= w_wdata;
      r_be[r_wptr]   <= w_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept && w_misalign;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(i) - r_rptr} < r_count) &&
          (r_addr[i] == ld_addr_i[ADDR_WIDTH-1:2]))
        w_hazard = 1'b1;
    end
  end

  assign w_unused_ld_lsb = &{1'b0, ld_addr_i[1:0]};

  assign hazard_o    = ld_valid_i && w_hazard;
  assign misalign_o  = r_misalign;
  assign count_o     = r_count;
  assign mem_we_o    = !w_empty;
  assign mem_addr_o  = w_empty ? '0 : {r_addr[r_rptr], 2'b00};
  assign mem_wdata_o = w_empty ? '0 : r_data[r_rptr];
  assign mem_be_o    = w_empty ? '0 : r_be[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_store_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_store_buf
// Brief    : Directed self-checking bench for data_mem_store_buf.
// Revision : 1.0
// ============================================================================
module tb_data_mem_store_buf;

  logic        clk;
  logic        rst_n;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [1:0]  mem_type_i;
  logic        misalign_o;
  logic        ld_valid_i;
  logic [31:0] ld_addr_i;
  logic        hazard_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i;
  logic [1:0]  count_o;

  int n_checks;
  int n_errors;

  data_mem_store_buf #(.ADDR_WIDTH(32), .DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid_i   (st_valid_i),
    .st_ready_o   (st_ready_o),
    .addr_i       (addr_i),
    .write_data_i (write_data_i),
    .mem_type_i   (mem_type_i),
    .misalign_o   (misalign_o),
    .ld_valid_i   (ld_valid_i),
    .ld_addr_i    (ld_addr_i),
    .hazard_o     (hazard_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_ready_i  (mem_ready_i),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    st_valid_i   = 1'b1;
    addr_i       = a;
    write_data_i = d;
    mem_type_i   = t;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    st_valid_i = 1'b0; addr_i = '0; write_data_i = '0; mem_type_i = 2'b11;
    ld_valid_i = 1'b1; ld_addr_i = 32'h0000_0000; mem_ready_i = 1'b1;
    step(); step();
    chk("rst_we",     {31'd0, mem_we_o},   32'd0);
    chk("rst_ready",  {31'd0, st_ready_o}, 32'd1);
    chk("rst_count",  {30'd0, count_o},    32'd0);
    chk("rst_mis",    {31'd0, misalign_o}, 32'd0);
    chk("rst_hazard", {31'd0, hazard_o},   32'd0);
    chk("rst_addr",   mem_addr_o,          32'd0);
    chk("rst_be",     {28'd0, mem_be_o},   32'd0);
    ld_valid_i = 1'b0;
    rst_n = 1'b1;
    step();

    // SB with immediate drain
    store(32'h1003, 32'h0000_00A5, 2'b01);
    step();
    st_valid_i = 1'b0;
    chk("sb_we",    {31'd0, mem_we_o},   32'd1);
    chk("sb_addr",  mem_addr_o,          32'h1000);
    chk("sb_wdata", mem_wdata_o,         32'hA5A5A5A5);
    chk("sb_be",    {28'd0, mem_be_o},   32'h8);
    chk("sb_cnt1",  {30'd0, count_o},    32'd1);
    step();
    chk("sb_cnt0",  {30'd0, count_o},    32'd0);
    chk("sb_we0",   {31'd0, mem_we_o},   32'd0);

    // SH then SW held by backpressure
    mem_ready_i = 1'b0;
    store(32'h2002, 32'h1234_BEEF, 2'b10);
    step();
    store(32'h2004, 32'hCAFE_F00D, 2'b11);
    step();
    st_valid_i = 1'b0;
    chk("full_cnt",   {30'd0, count_o},    32'd2);
    chk("full_ready", {31'd0, st_ready_o}, 32'd0);
    chk("sh_wdata",   mem_wdata_o,         32'hBEEFBEEF);
    chk("sh_be",      {28'd0, mem_be_o},   32'hC);
    step();
    chk("sh_hold_wd", mem_wdata_o,         32'hBEEFBEEF);
    chk("sh_hold_ad", mem_addr_o,          32'h2000);
    chk("sh_hold_be", {28'd0, mem_be_o},   32'hC);
    mem_ready_i = 1'b1;
    step();
    chk("sw_addr",  mem_addr_o,          32'h2004);
    chk("sw_wdata", mem_wdata_o,         32'hCAFEF00D);
    chk("sw_be",    {28'd0, mem_be_o},   32'hF);
    chk("sw_cnt",   {30'd0, count_o},    32'd1);
    step();
    chk("drain_cnt", {30'd0, count_o},   32'd0);

    // Misaligned stores, back to back, then an aligned SH
    mem_ready_i = 1'b0;
    store(32'h3001, 32'h1111_1111, 2'b11);
    step();
    chk("mis_sw",    {31'd0, misalign_o}, 32'd1);
    chk("mis_sw_we", {31'd0, mem_we_o},   32'd0);
    store(32'h3001, 32'h2222_2222, 2'b10);
    step();
    chk("mis_sh",     {31'd0, misalign_o}, 32'd1);
    chk("mis_sh_cnt", {30'd0, count_o},    32'd0);
    store(32'h3002, 32'h0000_5678, 2'b10);
    step();
    st_valid_i = 1'b0;
    chk("ok_sh_mis",  {31'd0, misalign_o}, 32'd0);
    chk("ok_sh_cnt",  {30'd0, count_o},    32'd1);
    chk("ok_sh_wd",   mem_wdata_o,         32'h56785678);
    chk("ok_sh_be",   {28'd0, mem_be_o},   32'hC);
    mem_ready_i = 1'b1;
    step();
    chk("ok_sh_drain", {30'd0, count_o},   32'd0);

    // Load-after-store hazard
    mem_ready_i = 1'b0;
    store(32'h4001, 32'h0000_0077, 2'b01);
    step();
    st_valid_i = 1'b0;
    ld_valid_i = 1'b1; ld_addr_i = 32'h4003;
    #1 chk("haz_hit", {31'd0, hazard_o}, 32'd1);
    ld_addr_i = 32'h4004;
    #1 chk("haz_miss", {31'd0, hazard_o}, 32'd0);
    ld_valid_i = 1'b0; ld_addr_i = 32'h4000;
    #1 chk("haz_noval", {31'd0, hazard_o}, 32'd0);
    mem_ready_i = 1'b1;
    step();
    ld_valid_i = 1'b1; ld_addr_i = 32'h4003;
    #1 chk("haz_drain", {31'd0, hazard_o}, 32'd0);
    ld_valid_i = 1'b0;

    // Sustained throughput, one store per cycle
    for (int k = 0; k < 8; k++) begin
      store(32'h5000 + 32'(4 * k), 32'h1000_0000 + 32'(k), 2'b11);
      step();
      chk($sformatf("thr_addr%0d", k), mem_addr_o,        32'h5000 + 32'(4 * k));
      chk($sformatf("thr_wd%0d", k),   mem_wdata_o,       32'h1000_0000 + 32'(k));
      chk($sformatf("thr_cnt%0d", k),  {30'd0, count_o},  32'd1);
    end
    st_valid_i = 1'b0;
    step();
    chk("thr_end", {30'd0, count_o}, 32'd0);

    // Store waits while full, accepted after a slot frees
    mem_ready_i = 1'b0;
    store(32'h6000, 32'h60, 2'b11);
    step();
    store(32'h6004, 32'h64, 2'b11);
    step();
    store(32'h6008, 32'h68, 2'b11);
    step();
    chk("wait_cnt",   {30'd0, count_o},    32'd2);
    chk("wait_head",  mem_addr_o,          32'h6000);
    mem_ready_i = 1'b1;
    step();
    mem_ready_i = 1'b0;
    chk("free_cnt",   {30'd0, count_o},    32'd1);
    chk("free_ready", {31'd0, st_ready_o}, 32'd1);
    chk("free_head",  mem_addr_o,          32'h6004);
    step();
    st_valid_i = 1'b0;
    chk("late_cnt",   {30'd0, count_o},    32'd2);
    chk("late_head",  mem_addr_o,          32'h6004);

    // Async reset mid-operation discards buffered stores
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we",    {31'd0, mem_we_o},   32'd0);
    chk("arst_cnt",   {30'd0, count_o},    32'd0);
    chk("arst_addr",  mem_addr_o,          32'd0);
    chk("arst_wdata", mem_wdata_o,         32'd0);
    mem_ready_i = 1'b1;
    step();
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_we", {31'd0, mem_we_o},  32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_store_buf.md
# data_mem_store_buf

Store-side companion to the load data formatter. It accepts stores from the memory stage, aligns the data and generates byte enables for SB/SH/SW, and queues them in a small FIFO. It drains the FIFO to the data memory's word-addressed write port under a valid/ready handshake. It also flags misaligned stores and reports load-after-store hazards against buffered entries.

## Interface
- ADDR_WIDTH, 32, address and data width.
- DEPTH, 2, store buffer entries; power of two, ≥2.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid_i  in  1  store request valid.
- st_ready_o  out  1  buffer can accept a store.
- addr_i  in  ADDR_WIDTH  byte address of the store.
- write_data_i  in  ADDR_WIDTH  unaligned source register data (rs2).
- mem_type_i  in  2  01 byte, 10 halfword, other word (same encoding as loads).
- misalign_o  out  1  one-cycle pulse: previous accepted store was misaligned and dropped.
- ld_valid_i  in  1  a load is in the memory stage.
- ld_addr_i  in  ADDR_WIDTH  load byte address.
- hazard_o  out  1  load word address matches a buffered store.
- mem_we_o  out  1  write request to data memory (FIFO head valid).
- mem_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- mem_wdata_o  out  ADDR_WIDTH  lane-replicated write data.
- mem_be_o  out  4  byte enables.
- mem_ready_i  in  1  memory accepts the write this cycle.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Accept = st_valid_i && st_ready_o. st_ready_o = (count < DEPTH), from registered state only. It does not depend on mem_ready_i, and there is no full-pass-through.
- Formatting at accept, with lane = addr_i[1:0]:
  - Byte: wdata = {4{write_data_i[7:0]}}, be = 4'b0001 << lane.
  - Half: wdata = {2{write_data_i[15:0]}}, be = lane[1] ? 4'b1100 : 4'b0011.
  - Word: wdata = write_data_i, be = 4'b1111.
- Misalignment: half with lane[0]=1, or word with lane≠0.
  - An accepted misaligned store is not enqueued.
  - misalign_o = 1 on the next cycle for exactly one cycle.
  - Back-to-back misaligned accepts give consecutive pulses.
- Each entry stores {addr_i[31:2], wdata, be}. Circular write/read pointers plus count.
- Head presentation:
  - mem_we_o = (count ≠ 0).
  - mem_addr_o/mem_wdata_o/mem_be_o come from the head entry, driven 0 when empty.
  - Head fields must hold stable while mem_we_o && !mem_ready_i.
- Dequeue = mem_we_o && mem_ready_i, which advances the read pointer.
- Simultaneous accept and dequeue (count < DEPTH): count unchanged, both pointers advance, wrap modulo DEPTH.
- hazard_o = ld_valid_i && any occupied entry's word address == ld_addr_i[31:2]. Purely combinational, entry is not written this cycle. No forwarding; the pipeline stalls the load while hazard_o = 1.

## Timing
- Reset (async assert, sync-safe deassert): count = 0, pointers = 0, misalign_o = 0.
  - Hence mem_we_o = 0, mem_addr_o/mem_wdata_o/mem_be_o = 0, st_ready_o = 1, hazard_o = 0.
  - Reset mid-operation discards all buffered stores.
- Latency: a store accepted in cycle N appears on mem_we_o in cycle N+1 when the buffer was empty. Minimum 1 cycle, no combinational st→mem path.
- Throughput: one store per cycle sustained when mem_ready_i is held 1.
- Full: st_ready_o = 0. A st_valid_i held during full waits and is accepted in the cycle after a dequeue frees a slot.
- Empty with mem_ready_i = 1: no dequeue, count stays 0.
- misalign_o is registered, 1 cycle after the accept.

## Test plan
- Reset, then SB addr 0x1003 data 0xA5 with mem_ready_i = 1 → next cycle mem_we_o = 1, addr 0x1000, wdata 0xA5A5A5A5, be 1000; count returns to 0.
- SH addr 0x2002 data 0x1234BEEF, then SW addr 0x2004 data 0xCAFEF00D, mem_ready_i = 0 → count = 2, st_ready_o = 0; head wdata 0xBEEFBEEF, be 1100 held stable. Raise mem_ready_i → SH then SW drained in order.
- SW addr 0x3001 → not enqueued, misalign_o = 1 for one cycle, mem_we_o stays 0. SH at 0x3001 also flags; SH at 0x3002 does not.
- Buffer holds SB to 0x4001 with mem_ready_i = 0. Load at 0x4003 → hazard_o = 1; load at 0x4004 → 0. After drain → 0.
- Continuous stores with mem_ready_i = 1 for 8 cycles → 8 writes in order, pointers wrap, count ≤ 1.
- Assert rst_n low with count = 2 → outputs zero immediately (async), buffered stores are never written.
